sd_block_sequencer: RTL and testbench

- Multi-sector transfer engine between the SD-card register window (sector address, start read/write, busy, page, 128-byte data window at 0x80-0xFF) and a byte-wide system memory port.
- Given a start sector, a sector count and a memory base address, it does the following for each sector:
  - programs the sector address;
  - starts the card operation;
  - polls busy;
  - moves the 512 bytes between the page-windowed sector buffer and memory.
- Frees the CPU from register-level sector handling during CP/M disk I/O.

---
 rtl/sd_block_sequencer_if.sv | 27 ++
 rtl/sd_block_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sd_block_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_sequencer_if.sv
// Register-window and byte-wide memory bus between the block sequencer (master)
// and the SD register window / system memory (slave).
interface sd_block_sequencer_if;
  logic [7:0]  reg_addr_o;
  logic [7:0]  reg_data_o;
  logic        reg_wr_n_o;
  logic        reg_cs_o;
  logic [7:0]  reg_data_i;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic [7:0]  mem_data_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        mem_ack_i;

  modport master (
    output reg_addr_o, reg_data_o, reg_wr_n_o, reg_cs_o,
    output mem_addr_o, mem_data_o, mem_req_o, mem_we_o,
    input  reg_data_i, mem_data_i, mem_ack_i
  );

  modport slave (
    input  reg_addr_o, reg_data_o, reg_wr_n_o, reg_cs_o,
    input  mem_addr_o, mem_data_o, mem_req_o, mem_we_o,
    output reg_data_i, mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/sd_block_sequencer.sv
// Multi-sector SD transfer engine: programs sector/start registers, polls busy and
// moves each 512-byte sector through the 4x128-byte page window to/from memory.
module sd_block_sequencer #(
  parameter int unsigned BUF_RD_LAT   = 2,
  parameter int unsigned RISE_WAIT    = 64,
  parameter logic [23:0] BUSY_TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic [31:0] sector_i,
  input  logic [7:0]  count_i,
  input  logic [15:0] mem_base_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [7:0]  sectors_done_o,
  sd_block_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, SET_ADDR, START_RD, START_WR, WAIT_RISE, WAIT_FALL, PAGE_R, PAGE_W, NEXT, FINISH
  } state_t;

  // Sub-steps inside the page states: page-register write, buffer read,
  // memory handshake, buffer write (setup then strobe).
  typedef enum logic [2:0] {PH_PGA, PH_PGB, PH_RD, PH_MEM, PH_WA, PH_WB} phase_t;

  state_t      state, state_n;
  phase_t      ph, ph_n;
  logic [23:0] cnt, cnt_n;
  logic [1:0]  page, page_n;
  logic [6:0]  idx, idx_n;
  logic        dir_q, dir_n;
  logic [31:0] sector_q, sector_n;
  logic [7:0]  count_q, count_n;
  logic [15:0] maddr, maddr_n;
  logic [7:0]  dbuf, dbuf_n;
  logic [1:0]  err_q, err_n;
  logic [7:0]  sdone_q, sdone_n;

  logic [7:0]  r_addr, r_data;
  logic        r_cs, r_wr_n, m_req, m_we, adv;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      ph       <= PH_PGA;
      cnt      <= '0;
      page     <= '0;
      idx      <= '0;
      dir_q    <= 1'b0;
      sector_q <= '0;
      count_q  <= '0;
      maddr    <= '0;
      dbuf     <= '0;
      err_q    <= '0;
      sdone_q  <= '0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      cnt      <= cnt_n;
      page     <= page_n;
      idx      <= idx_n;
      dir_q    <= dir_n;
      sector_q <= sector_n;
      count_q  <= count_n;
      maddr    <= maddr_n;
      dbuf     <= dbuf_n;
      err_q    <= err_n;
      sdone_q  <= sdone_n;
    end
  end

  always_comb begin
    state_n  = state;
    ph_n     = ph;
    cnt_n    = cnt;
    page_n   = page;
    idx_n    = idx;
    dir_n    = dir_q;
    sector_n = sector_q;
    count_n  = count_q;
    maddr_n  = maddr;
    dbuf_n   = dbuf;
    err_n    = err_q;
    sdone_n  = sdone_q;
    r_addr   = 8'h00;
    r_data   = 8'h00;
    r_cs     = 1'b0;
    r_wr_n   = 1'b1;
    m_req    = 1'b0;
    m_we     = 1'b0;
    adv      = 1'b0;

    unique case (state)
      IDLE: if (start_i) begin
        dir_n    = dir_i;
        sector_n = sector_i;
        count_n  = count_i;
        maddr_n  = mem_base_i;
        sdone_n  = '0;
        err_n    = 2'd0;
        cnt_n    = '0;
        ph_n     = PH_PGA;
        page_n   = '0;
        idx_n    = '0;
        if (count_i == 8'd0) begin
          err_n   = 2'd1;
          state_n = FINISH;
        end else begin
          state_n = dir_i ? PAGE_W : SET_ADDR;
        end
      end

      // Even cnt = setup cycle, odd cnt = strobe cycle; LSB byte first.
      SET_ADDR: begin
        r_addr = {6'd0, cnt[2:1]};
        r_data = sector_q[{cnt[2:1], 3'b000} +: 8];
        r_cs   = cnt[0];
        r_wr_n = ~cnt[0];
        cnt_n  = cnt + 24'd1;
        if (cnt[2:0] == 3'd7) begin
          cnt_n   = '0;
          state_n = dir_q ? START_WR : START_RD;
        end
      end

      START_RD, START_WR: begin
        r_addr = (state == START_WR) ? 8'h06 : 8'h05;
        r_cs   = cnt[0];
        r_wr_n = ~cnt[0];
        cnt_n  = cnt + 24'd1;
        if (cnt[0]) begin
          cnt_n   = '0;
          state_n = WAIT_RISE;
        end
      end

      // Status address is held for the whole poll, so from the second cycle on
      // reg_data_i always reflects the status register.
      WAIT_RISE: begin
        r_addr = 8'h04;
        r_cs   = 1'b1;
        cnt_n  = cnt + 24'd1;
        if (cnt != '0 && bus.reg_data_i[0]) begin
          cnt_n   = '0;
          state_n = WAIT_FALL;
        end else if (cnt >= 24'(RISE_WAIT)) begin
          err_n   = 2'd2;
          state_n = FINISH;
        end
      end

      WAIT_FALL: begin
        r_addr = 8'h04;
        r_cs   = 1'b1;
        cnt_n  = cnt + 24'd1;
        if (cnt != '0 && !bus.reg_data_i[0]) begin
          cnt_n   = '0;
          ph_n    = PH_PGA;
          page_n  = '0;
          idx_n   = '0;
          state_n = dir_q ? NEXT : PAGE_R;
        end else if (cnt >= BUSY_TIMEOUT) begin
          err_n   = 2'd3;
          state_n = FINISH;
        end
      end

      PAGE_R, PAGE_W: begin
        unique case (ph)
          PH_PGA: begin
            r_addr = 8'h07;
            r_data = {6'd0, page};
            ph_n   = PH_PGB;
          end
          PH_PGB: begin
            r_addr = 8'h07;
            r_data = {6'd0, page};
            r_cs   = 1'b1;
            r_wr_n = 1'b0;
            cnt_n  = '0;
            ph_n   = (state == PAGE_R) ? PH_RD : PH_MEM;
          end
          PH_RD: begin
            r_addr = {1'b1, idx};
            r_cs   = 1'b1;
            cnt_n  = cnt + 24'd1;
            if (cnt == 24'(BUF_RD_LAT)) begin
              dbuf_n = bus.reg_data_i;
              ph_n   = PH_MEM;
            end
          end
          PH_MEM: begin
            m_req = 1'b1;
            m_we  = (state == PAGE_R);
            if (bus.mem_ack_i) begin
              maddr_n = maddr + 16'd1;
              if (state == PAGE_R) begin
                adv = 1'b1;
              end else begin
                dbuf_n = bus.mem_data_i;
                ph_n   = PH_WA;
              end
            end
          end
          PH_WA: begin
            r_addr = {1'b1, idx};
            r_data = dbuf;
            ph_n   = PH_WB;
          end
          PH_WB: begin
            r_addr = {1'b1, idx};
            r_data = dbuf;
            r_cs   = 1'b1;
            r_wr_n = 1'b0;
            adv    = 1'b1;
          end
          default: ph_n = PH_PGA;
        endcase
        // idx and page wrap naturally to 0 at the end of a page / sector.
        if (adv) begin
          cnt_n = '0;
          idx_n = idx + 7'd1;
          ph_n  = (state == PAGE_R) ? PH_RD : PH_MEM;
          if (&idx) begin
            page_n = page + 2'd1;
            ph_n   = PH_PGA;
            if (&page) state_n = (state == PAGE_R) ? NEXT : SET_ADDR;
          end
        end
      end

      NEXT: begin
        sdone_n  = sdone_q + 8'd1;
        sector_n = sector_q + 32'd1;
        cnt_n    = '0;
        ph_n     = PH_PGA;
        page_n   = '0;
        idx_n    = '0;
        if (sdone_q + 8'd1 == count_q) state_n = FINISH;
        else                           state_n = dir_q ? PAGE_W : SET_ADDR;
      end

      FINISH: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  assign busy_o          = (state != IDLE);
  assign done_o          = (state == FINISH);
  assign err_o           = err_q;
  assign sectors_done_o  = sdone_q;

  assign bus.reg_addr_o  = r_addr;
  assign bus.reg_data_o  = r_data;
  assign bus.reg_cs_o    = r_cs;
  assign bus.reg_wr_n_o  = r_wr_n;
  assign bus.mem_addr_o  = maddr;
  assign bus.mem_data_o  = dbuf;
  assign bus.mem_req_o   = m_req;
  assign bus.mem_we_o    = m_we;

endmodule

// File: tb/tb_sd_block_sequencer.sv
// Directed bench for sd_block_sequencer: card/memory models plus queue scoreboards
// for register-window writes and memory writes.
module tb_sd_block_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, dir;
  logic [31:0] sector;
  logic [7:0]  count;
  logic [15:0] base;
  logic        busy, done;
  logic [1:0]  err;
  logic [7:0]  sdone;

  always #5 clk = ~clk;

  sd_block_sequencer_if bus();

  sd_block_sequencer #(.BUF_RD_LAT(2), .RISE_WAIT(64), .BUSY_TIMEOUT(24'd100)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .dir_i(dir), .sector_i(sector),
    .count_i(count), .mem_base_i(base), .busy_o(busy), .done_o(done), .err_o(err),
    .sectors_done_o(sdone), .bus(bus)
  );

  int errs = 0;
  int checks = 0;

  // card model: 0 normal busy pulse, 1 busy never rises, 2 busy stuck high
  int          mode = 0;
  logic [31:0] c_sector;
  logic [1:0]  c_page;
  logic [7:0]  c_tmr, a1, rb1, rb2;
  logic        stat1, c_busy;
  logic [15:0] wbase = 16'h0;

  function automatic logic [7:0] rdbyte(input logic [31:0] s, input logic [8:0] i);
    return i[7:0] ^ (s[7:0] - 8'h34);
  endfunction

  assign c_busy = (mode == 1) ? 1'b0 :
                  (mode == 2) ? (c_tmr >= 8'd4) : (c_tmr >= 8'd4 && c_tmr < 8'd24);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sector <= '0; c_page <= '0; c_tmr <= '0;
      a1 <= '0; rb1 <= '0; rb2 <= '0; stat1 <= 1'b0;
    end else begin
      a1    <= bus.reg_cs_o ? bus.reg_addr_o : 8'h00;
      rb1   <= rdbyte(c_sector, {c_page, bus.reg_addr_o[6:0]});
      rb2   <= rb1;
      stat1 <= c_busy;
      if (c_tmr != 8'd0 && c_tmr != 8'hFF) c_tmr <= c_tmr + 8'd1;
      if (bus.reg_cs_o && !bus.reg_wr_n_o) begin
        case (bus.reg_addr_o)
          8'h00: c_sector[7:0]   <= bus.reg_data_o;
          8'h01: c_sector[15:8]  <= bus.reg_data_o;
          8'h02: c_sector[23:16] <= bus.reg_data_o;
          8'h03: c_sector[31:24] <= bus.reg_data_o;
          8'h05, 8'h06: c_tmr <= 8'd1;
          8'h07: c_page <= bus.reg_data_o[1:0];
          default: ;
        endcase
      end
    end
  end

  // status reads have 1-cycle latency, buffer reads 2 cycles
  assign bus.reg_data_i = (a1 == 8'h04) ? {7'd0, stat1} : rb2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ack_i  <= 1'b0;
      bus.mem_data_i <= 8'h00;
    end else if (bus.mem_req_o && !bus.mem_ack_i && $urandom_range(0, 1) == 1) begin
      bus.mem_ack_i  <= 1'b1;
      bus.mem_data_i <= 8'hA5 ^ 8'(bus.mem_addr_o - wbase);
    end else begin
      bus.mem_ack_i  <= 1'b0;
    end
  end

  logic [15:0] exp_reg[$];
  logic [23:0] exp_mem[$];
  logic [15:0] er;
  logic [23:0] em;
  logic [15:0] last_maddr = 16'h0;
  int          cs_cnt = 0;
  int          done_cnt = 0;
  logic        p_cs = 1'b0, p_wr_n = 1'b1;
  logic [7:0]  p_addr = 8'h0, p_data = 8'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_addr(input logic [31:0] s);
    for (int k = 0; k < 4; k++) exp_reg.push_back({k[7:0], s[8*k +: 8]});
  endtask

  task automatic push_read(input logic [31:0] s, input logic [15:0] b);
    push_addr(s);
    exp_reg.push_back(16'h0500);
    for (int p = 0; p < 4; p++) exp_reg.push_back({8'h07, 6'd0, p[1:0]});
    for (int i = 0; i < 512; i++) exp_mem.push_back({16'(b + 16'(i)), rdbyte(s, i[8:0])});
  endtask

  task automatic push_write(input logic [31:0] s);
    for (int p = 0; p < 4; p++) begin
      exp_reg.push_back({8'h07, 6'd0, p[1:0]});
      for (int i = 0; i < 128; i++) begin
        int j;
        j = p * 128 + i;
        exp_reg.push_back({8'h80 | i[7:0], 8'hA5 ^ j[7:0]});
      end
    end
    push_addr(s);
    exp_reg.push_back(16'h0600);
  endtask

  task automatic do_start(input logic d, input logic [31:0] s, input logic [7:0] c,
                          input logic [15:0] b);
    @(negedge clk);
    dir = d; sector = s; count = c; base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {busy, done, err, sdone, bus.reg_wr_n_o, bus.reg_cs_o, bus.mem_req_o, bus.mem_we_o},
          {1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check({tag, "_bus"}, {bus.reg_addr_o, bus.reg_data_o, bus.mem_addr_o}, 32'h0);
    check({tag, "_mdata"}, bus.mem_data_o, 0);
  endtask

  initial begin
    start = 1'b0; dir = 1'b0; sector = '0; count = '0; base = '0;

    fork
      forever begin
        @(negedge clk);
        if (bus.reg_cs_o) cs_cnt++;
        if (done) done_cnt++;
        if (bus.reg_cs_o && !bus.reg_wr_n_o) begin
          check("reg_setup", {14'd0, p_cs, p_wr_n, p_addr, p_data},
                {14'd0, 1'b0, 1'b1, bus.reg_addr_o, bus.reg_data_o});
          if (exp_reg.size() == 0) begin
            checks++; errs++;
            $error("FAIL reg_extra: got %0h expected none", {bus.reg_addr_o, bus.reg_data_o});
          end else begin
            er = exp_reg.pop_front();
            check("reg_wr", {16'd0, bus.reg_addr_o, bus.reg_data_o}, {16'd0, er});
          end
        end
        if (bus.mem_req_o && bus.mem_ack_i && bus.mem_we_o) begin
          last_maddr = bus.mem_addr_o;
          if (exp_mem.size() == 0) begin
            checks++; errs++;
            $error("FAIL mem_extra: got %0h expected none", {bus.mem_addr_o, bus.mem_data_o});
          end else begin
            em = exp_mem.pop_front();
            check("mem_wr", {8'd0, bus.mem_addr_o, bus.mem_data_o}, {8'd0, em});
          end
        end
        p_cs = bus.reg_cs_o; p_wr_n = bus.reg_wr_n_o;
        p_addr = bus.reg_addr_o; p_data = bus.reg_data_o;
      end
    join_none

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // single-sector read
    mode = 0;
    push_read(32'h1234, 16'h4000);
    do_start(1'b0, 32'h1234, 8'd1, 16'h4000);
    check("t1_busy", busy, 1);
    wait_done("t1_done", 8000);
    check("t1_err", err, 0);
    check("t1_sdone", sdone, 1);
    check("t1_last", last_maddr, 16'h41FF);
    check("t1_qreg", exp_reg.size(), 0);
    check("t1_qmem", exp_mem.size(), 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // three sectors with address wrap; a start mid-transfer is ignored
    for (int k = 0; k < 3; k++) push_read(32'h1234 + k, 16'hFF00 + 16'(k * 512));
    do_start(1'b0, 32'h1234, 8'd3, 16'hFF00);
    repeat (200) @(negedge clk);
    start = 1'b1; dir = 1'b1; sector = 32'h0; count = 8'd1; base = 16'h0;
    @(negedge clk);
    start = 1'b0;
    check("t2_busy_ign", busy, 1);
    wait_done("t2_done", 24000);
    check("t2_err", err, 0);
    check("t2_sdone", sdone, 3);
    check("t2_last", last_maddr, 16'h04FF);
    check("t2_qreg", exp_reg.size(), 0);
    check("t2_qmem", exp_mem.size(), 0);

    // single-sector write, memory pattern 0xA5^i
    wbase = 16'h2000;
    push_write(32'h00ABCDEF);
    do_start(1'b1, 32'h00ABCDEF, 8'd1, 16'h2000);
    wait_done("t3_done", 8000);
    check("t3_err", err, 0);
    check("t3_sdone", sdone, 1);
    check("t3_qreg", exp_reg.size(), 0);

    // busy never rises
    mode = 1;
    push_addr(32'h77); exp_reg.push_back(16'h0500);
    do_start(1'b0, 32'h77, 8'd2, 16'h1000);
    wait_done("t5_done", 500);
    check("t5_err", err, 2);
    check("t5_sdone", sdone, 0);
    check("t5_qreg", exp_reg.size(), 0);

    // busy stuck high
    mode = 2;
    push_addr(32'h78); exp_reg.push_back(16'h0500);
    do_start(1'b0, 32'h78, 8'd2, 16'h1000);
    wait_done("t6_done", 1000);
    check("t6_err", err, 3);
    check("t6_sdone", sdone, 0);
    check("t6_qreg", exp_reg.size(), 0);

    // reset during PAGE_R of the second sector
    mode = 0;
    wbase = 16'h0;
    push_read(32'h1234, 16'h3000);
    push_read(32'h1235, 16'h3200);
    do_start(1'b0, 32'h1234, 8'd2, 16'h3000);
    begin
      int n;
      n = 0;
      while (exp_mem.size() > 500 && n < 20000) begin
        @(negedge clk);
        n++;
      end
    end
    check("t7_reach", exp_mem.size() <= 500, 1);
    check("t7_sdone_pre", sdone, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t7_rst");
    exp_reg.delete();
    exp_mem.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_idle", busy, 0);

    // zero count: no register activity, done next cycle
    cs_cnt = 0;
    done_cnt = 0;
    do_start(1'b0, 32'h5, 8'd0, 16'h0);
    check("t4_done", done, 1);
    check("t4_err", err, 1);
    @(negedge clk);
    check("t4_done_drop", done, 0);
    repeat (5) @(negedge clk);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_cs", cs_cnt, 0);
    check("t4_idle", busy, 0);
    check("t4_sdone", sdone, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
